light_monitor: RTL
==================

# light_monitor

Passive checker on the traffic-light output bus, on the receiving end of `light[1:0]`. It decodes the light value and tracks which phase the light is in and how long it has been there. It flags illegal codes, illegal phase order and wrong phase durations, and counts complete green→yellow→red periods. It sits beside the light controller in the top level and in the bench, and drives no part of the controller's datapath.

## Interface
- `GREEN_CYCLES`, 8, required green dwell in clocks
- `YELLOW_CYCLES`, 2, required yellow dwell in clocks
- `RED_CYCLES`, 6, required red dwell in clocks
- `CNT_W`, 8, dwell counter width; must hold max(dwell)+1
- `PERIOD_W`, 16, period counter width
- `clk`  in  1  single clock, rising edge
- `rstb`  in  1  asynchronous, active-low reset
- `light`  in  2  observed light; 00 GREEN, 01 YELLOW, 10 RED, 11 illegal
- `clr`  in  1  synchronous clear of errors, period count and tracking
- `phase`  out  2  last sampled legal light value
- `dwell`  out  CNT_W  consecutive cycles `phase` has held, saturating
- `period_done`  out  1  one-cycle pulse on each checked RED→GREEN change
- `period_cnt`  out  PERIOD_W  completed periods, wraps to 0
- `err`  out  1  sticky error flag
- `err_code`  out  3  first error since reset/clr: 0 none, 1 ILLEGAL, 2 BAD_SEQ, 3 SHORT, 4 LONG

## Operation
- `light` is compared each cycle against the registered `phase`. A "change" is `light != phase`.
- States:
  - IDLE (reset/clr/after any error): next edge loads `phase` from `light`, sets `dwell`=1 and goes to TRACK. If `light`=11, it stays in IDLE and flags ILLEGAL.
  - TRACK: the first phase is partial, so its duration is unchecked. The first legal change loads the new phase, sets `dwell`=1 and goes to CHECK.
  - CHECK: full checking applies.
- Legal order is only GREEN→YELLOW→RED→GREEN. Any other change is BAD_SEQ.
- `light`=11 in any state is ILLEGAL.
- Duration checks in CHECK:
  - A change with ending `dwell` < required is SHORT.
  - `dwell` reaching required+1 with no change is LONG, flagged at once so a stuck light is caught.
- Priority when several errors occur in one cycle: ILLEGAL > BAD_SEQ > SHORT > LONG.
- On any error:
  - `err` goes to 1.
  - `err_code` latches only if it was 0.
  - State goes to IDLE and `phase` holds.
- `period_done`=1 and `period_cnt`+1 on a legal RED→GREEN change in CHECK that is free of errors.
- `clr` goes to IDLE, clears `err`, `err_code`, `period_cnt` and `dwell`, and wins over a same-cycle error or period event.

## Timing
- Reset values: `phase`=00, `dwell`=0, `period_done`=0, `period_cnt`=0, `err`=0, `err_code`=0, state IDLE.
- `rstb` low forces these values immediately, including mid-phase.
- All outputs are registered. The response to the `light` value present before edge k appears after edge k (latency 1).
- `dwell` is 1 in the cycle after a change is sampled and increments each cycle while unchanged. It saturates at all-ones.
- `period_cnt` wraps from all-ones to 0 without an error.
- After reset release the first sampled phase is never duration-checked.

## Configuration
- `LIGHT_MON_DURATION_CHK_EN`
  - Defined: SHORT and LONG checks are active as described.
  - Undefined: SHORT and LONG are never raised. The order and code checks, `dwell`, `period_done` and `period_cnt` are unchanged.

## Structure
- Package `light_mon_pkg` holds:
  - light encodings `LIGHT_GREEN`, `LIGHT_YELLOW`, `LIGHT_RED`;
  - error codes `ERR_NONE`…`ERR_LONG`;
  - the state enum `IDLE`/`TRACK`/`CHECK`.
- Sub-module `light_dwell_cnt`: saturating counter with synchronous load-to-1 and clear, parameterized by `CNT_W`.
- The FSM, checks and period counter stay in `light_monitor`.

## Test plan
- Legal stream (partial GREEN 3, then YELLOW 2, RED 6, GREEN 8, YELLOW 2, RED 6, GREEN) → `err`=0, `period_done` pulses exactly twice, `period_cnt`=2.
- `light`=11 for one cycle mid-GREEN in CHECK → `err`=1 and `err_code`=1 after that edge. A later legal stream resynchronizes through IDLE/TRACK with `err_code` still 1.
- GREEN held 8 then RED directly → `err_code`=2, `period_cnt` unchanged.
- YELLOW held 1 cycle in CHECK:
  - macro defined → `err_code`=3;
  - macro undefined → `err`=0 and the stream continues.
- RED held 10 cycles in CHECK → `err_code`=4 after the edge sampling the 7th RED cycle. Pulsing `clr` → `err`=0, `err_code`=0, `period_cnt`=0.
- `rstb` low mid-RED for half a cycle → all outputs 0 immediately. After release, a RED remainder of 2 cycles gives no SHORT error.

Source files
------------

// File: rtl/light_mon_pkg.sv
// Shared encodings for the traffic-light output monitor.
package light_mon_pkg;

  localparam logic [1:0] LIGHT_GREEN   = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_RED     = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ILLEGAL = 3'd1,
    ERR_BAD_SEQ = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_LONG    = 3'd4
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    CHECK = 2'd2
  } mon_state_e;

  // The only legal successor of each phase in the GREEN->YELLOW->RED cycle.
  function automatic logic [1:0] next_legal(input logic [1:0] p);
    case (p)
      LIGHT_GREEN:  next_legal = LIGHT_YELLOW;
      LIGHT_YELLOW: next_legal = LIGHT_RED;
      default:      next_legal = LIGHT_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/light_dwell_cnt.sv
// Saturating dwell counter with synchronous clear and load-to-1.
module light_dwell_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             load,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/light_monitor.sv
// Passive checker for the light[1:0] bus: phase order, dwell and period counting.
// Define LIGHT_MON_DURATION_CHK_EN to enable the SHORT/LONG duration checks.
module light_monitor
  import light_mon_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 8,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned RED_CYCLES    = 6,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned PERIOD_W      = 16
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [1:0]          light,
  input  logic                clr,
  output logic [1:0]          phase,
  output logic [CNT_W-1:0]    dwell,
  output logic                period_done,
  output logic [PERIOD_W-1:0] period_cnt,
  output logic                err,
  output logic [2:0]          err_code
);

`ifdef LIGHT_MON_DURATION_CHK_EN
  localparam bit DurChkEn = 1'b1;
`else
  localparam bit DurChkEn = 1'b0;
`endif

  mon_state_e          state_d, state_q;
  logic [1:0]          phase_d, phase_q;
  logic                period_done_d, period_done_q;
  logic [PERIOD_W-1:0] period_cnt_d, period_cnt_q;
  logic                err_d, err_q;
  err_code_e           err_code_d, err_code_q;
  err_code_e           err_new;
  logic [CNT_W-1:0]    dwell_cnt;
  logic [CNT_W-1:0]    required;
  logic                dwell_load, dwell_clr;
  logic                changed, illegal, in_order;

  light_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk  (clk),
    .rstb (rstb),
    .clr  (dwell_clr),
    .load (dwell_load),
    .cnt  (dwell_cnt)
  );

  always_comb begin
    case (phase_q)
      LIGHT_YELLOW: required = CNT_W'(YELLOW_CYCLES);
      LIGHT_RED:    required = CNT_W'(RED_CYCLES);
      default:      required = CNT_W'(GREEN_CYCLES);
    endcase

    changed  = (light != phase_q);
    illegal  = (light == LIGHT_ILLEGAL);
    in_order = (light == next_legal(phase_q));

    // Chain order encodes error priority: ILLEGAL > BAD_SEQ > SHORT > LONG.
    err_new = ERR_NONE;
    if (illegal) begin
      err_new = ERR_ILLEGAL;
    end else if (state_q != IDLE && changed && !in_order) begin
      err_new = ERR_BAD_SEQ;
    end else if (DurChkEn && state_q == CHECK && changed && dwell_cnt < required) begin
      err_new = ERR_SHORT;
    end else if (DurChkEn && state_q == CHECK && !changed && dwell_cnt >= required) begin
      err_new = ERR_LONG;
    end

    state_d       = state_q;
    phase_d       = phase_q;
    period_done_d = 1'b0;
    period_cnt_d  = period_cnt_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    dwell_load    = 1'b0;
    dwell_clr     = 1'b0;

    if (clr) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      err_d        = 1'b0;
      err_code_d   = ERR_NONE;
      dwell_clr    = 1'b1;
    end else if (err_new != ERR_NONE) begin
      state_d = IDLE;
      err_d   = 1'b1;
      if (err_code_q == ERR_NONE) begin
        err_code_d = err_new;
      end
    end else if (state_q == IDLE) begin
      phase_d    = light;
      dwell_load = 1'b1;
      state_d    = TRACK;
    end else if (changed) begin
      phase_d    = light;
      dwell_load = 1'b1;
      state_d    = CHECK;
      if (state_q == CHECK && phase_q == LIGHT_RED) begin
        period_done_d = 1'b1;
        period_cnt_d  = period_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      phase_q       <= LIGHT_GREEN;
      period_done_q <= 1'b0;
      period_cnt_q  <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      period_done_q <= period_done_d;
      period_cnt_q  <= period_cnt_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign phase       = phase_q;
  assign dwell       = dwell_cnt;
  assign period_done = period_done_q;
  assign period_cnt  = period_cnt_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
